// File: rtl/packet_ingress_if.sv
// packet_ingress_if: valid/ready spike packet handshake from the router
interface packet_ingress_if;
  logic        in_valid;
  logic [11:0] in_packet;
  logic        in_ready;
  modport master (output in_valid, output in_packet, input in_ready);
  modport slave  (input in_valid, input in_packet, output in_ready);
endinterface

// File: rtl/packet_ingress.sv
// packet_ingress: buffers router spike packets and writes them to the scheduler, sequencing tick clear/advance
module packet_ingress #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  packet_ingress_if.slave          in_if,
  input  logic                     tick,
  output logic                     sch_wen,
  output logic [11:0]              sch_packet,
  output logic                     sch_clr,
  output logic                     sch_set,
  input  logic                     sch_error,
  output logic                     tick_done,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [7:0]               err_count,
  output logic                     tick_overrun
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, DRAIN, FLUSH, CLR, SET} state_t;
  state_t         state_q, state_d;
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           pend_q, pend_d, ovr_q, ovr_d;
  logic           wen_q, wen_d, clr_q, clr_d, set_q, set_d, done_q, done_d;
  logic [11:0]    pkt_q, pkt_d;
  logic [7:0]     err_q, err_d;
  logic [11:0]    mem [DEPTH];
  logic           push, pop;
  assign in_if.in_ready = (cnt_q != (AW+1)'(DEPTH)) && (state_q == IDLE || state_q == DRAIN);
  assign push = in_if.in_valid && in_if.in_ready;
  assign pop  = (state_q == DRAIN || state_q == FLUSH) && cnt_q != '0;
  always_comb begin
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    // the SET cycle consumes the pending tick, so a tick landing there starts a fresh one
    pend_d  = (state_q == SET) ? tick : (pend_q | tick);
    ovr_d   = ovr_q | (tick & pend_q & (state_q != SET));
    state_d = (state_q == IDLE)  ? (pend_q ? FLUSH : (cnt_q != '0 ? DRAIN : IDLE)) :
              (state_q == DRAIN) ? (pend_q ? FLUSH : (cnt_q == '0 ? IDLE : DRAIN)) :
              (state_q == FLUSH) ? (cnt_q == '0 ? CLR : FLUSH) :
              (state_q == CLR)   ? SET : IDLE;
    wen_d   = pop;
    pkt_d   = pop ? mem[rd_q] : pkt_q;
    clr_d   = state_d == CLR;
    set_d   = state_d == SET;
    done_d  = state_d == SET;
    err_d   = (wen_q && sch_error && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      wen_q   <= 1'b0;
      clr_q   <= 1'b0;
      set_q   <= 1'b0;
      done_q  <= 1'b0;
      pkt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      wen_q   <= wen_d;
      clr_q   <= clr_d;
      set_q   <= set_d;
      done_q  <= done_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= in_if.in_packet;
  end
  assign sch_wen      = wen_q;
  assign sch_packet   = pkt_q;
  assign sch_clr      = clr_q;
  assign sch_set      = set_q;
  assign tick_done    = done_q;
  assign occupancy    = cnt_q;
  assign err_count    = err_q;
  assign tick_overrun = ovr_q;
endmodule
